// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched
//   Two-road intersection phase scheduler. Drives road A / road B lamps through
//   green, yellow and all-red clearance. A green ends on vehicle / pedestrian
//   demand, bounded by a minimum and a maximum green time. A latched pedestrian
//   request inserts a walk phase after the all-red of the side being left.
//
// Ports
//   clk      in   single clock
//   reset    in   synchronous, active-high
//   Ta, Tb   in   vehicle present on road A / road B
//   ped_req  in   pedestrian button (level or pulse), latched on any cycle
//   LA, LB   out  lamps, one-hot {red, yellow, green}
//   walk     out  pedestrian walk lamp
//   phase    out  current state code (debug)
module traffic_phase_sched #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned GREEN_MIN = 5,
  parameter int unsigned GREEN_MAX = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned PED_T     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       ped_req,
  output logic [2:0] LA,
  output logic [2:0] LB,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    GRN_A  = 3'd0,
    YEL_A  = 3'd1,
    RED_A  = 3'd2,
    WALK_A = 3'd3,
    GRN_B  = 3'd4,
    YEL_B  = 3'd5,
    RED_B  = 3'd6,
    WALK_B = 3'd7
  } state_t;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] C_TDIV = PW'(TICK_DIV - 1);
  localparam logic [7:0]    C_GMIN = 8'(GREEN_MIN);
  localparam logic [7:0]    C_GMAX = 8'(GREEN_MAX);
  localparam logic [7:0]    C_YEL  = 8'(YELLOW_T);
  localparam logic [7:0]    C_AR   = 8'(ALLRED_T);
  localparam logic [7:0]    C_PED  = 8'(PED_T);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  state_t         r_state;
  state_t         w_next;
  logic [PW-1:0]  r_presc;
  logic [7:0]     r_ph_cnt;
  logic           r_ped_pend;
  logic           w_tick;
  logic [7:0]     w_n;
  logic           w_dem_a;
  logic           w_dem_b;
  logic           w_trans;
  logic           w_enter_walk;

  // Free-running prescaler; never realigned on a state change, so every state
  // begins on a tick boundary.
  assign w_tick = (r_presc == C_TDIV);

  always_ff @(posedge clk) begin
    if (reset)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Ticks completed including the current one, saturating.
  assign w_n = (r_ph_cnt == 8'hFF) ? 8'hFF : r_ph_cnt + 8'd1;

  assign w_dem_a = Tb | r_ped_pend;
  assign w_dem_b = Ta | r_ped_pend;

  always_comb begin
    w_next = r_state;
    if (w_tick) begin
      case (r_state)
        GRN_A:  if (((w_n >= C_GMIN) && w_dem_a && !Ta) ||
                    ((w_n >= C_GMAX) && w_dem_a))          w_next = YEL_A;
        YEL_A:  if (w_n == C_YEL)                          w_next = RED_A;
        RED_A:  if (w_n == C_AR) w_next = r_ped_pend ? WALK_A : GRN_B;
        WALK_A: if (w_n == C_PED)                          w_next = GRN_B;
        GRN_B:  if (((w_n >= C_GMIN) && w_dem_b && !Tb) ||
                    ((w_n >= C_GMAX) && w_dem_b))          w_next = YEL_B;
        YEL_B:  if (w_n == C_YEL)                          w_next = RED_B;
        RED_B:  if (w_n == C_AR) w_next = r_ped_pend ? WALK_B : GRN_A;
        WALK_B: if (w_n == C_PED)                          w_next = GRN_A;
        default:                                           w_next = GRN_A;
      endcase
    end
  end

  // w_next differs from r_state only in a tick cycle.
  assign w_trans      = (w_next != r_state);
  assign w_enter_walk = w_trans && ((w_next == WALK_A) || (w_next == WALK_B));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= GRN_A;
      r_ph_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_tick) r_ph_cnt <= w_trans ? 8'd0 : w_n;
    end
  end

  // A press coinciding with walk entry stays latched for the next crossing.
  always_ff @(posedge clk) begin
    if (reset)             r_ped_pend <= 1'b0;
    else if (ped_req)      r_ped_pend <= 1'b1;
    else if (w_enter_walk) r_ped_pend <= 1'b0;
  end

  always_comb begin
    LA = L_RED;
    LB = L_RED;
    case (r_state)
      GRN_A:   LA = L_GRN;
      YEL_A:   LA = L_YEL;
      GRN_B:   LB = L_GRN;
      YEL_B:   LB = L_YEL;
      default: ;
    endcase
  end

  assign walk  = (r_state == WALK_A) || (r_state == WALK_B);
  assign phase = r_state;

endmodule

// File: tb/tb_traffic_phase_sched.sv
module tb_traffic_phase_sched;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, Ta, Tb, ped_req;
  logic [2:0] LA, LB, phase;
  logic       walk;

  logic       reset4, Ta4, Tb4, ped_req4;
  logic [2:0] LA4, LB4, phase4;
  logic       walk4;

  traffic_phase_sched #(
    .TICK_DIV(1), .GREEN_MIN(2), .GREEN_MAX(4),
    .YELLOW_T(2), .ALLRED_T(1), .PED_T(3)
  ) dut (
    .clk(clk), .reset(reset), .Ta(Ta), .Tb(Tb), .ped_req(ped_req),
    .LA(LA), .LB(LB), .walk(walk), .phase(phase)
  );

  traffic_phase_sched #(
    .TICK_DIV(4), .GREEN_MIN(2), .GREEN_MAX(4),
    .YELLOW_T(2), .ALLRED_T(1), .PED_T(3)
  ) dut4 (
    .clk(clk), .reset(reset4), .Ta(Ta4), .Tb(Tb4), .ped_req(ped_req4),
    .LA(LA4), .LB(LB4), .walk(walk4), .phase(phase4)
  );

  typedef struct {
    string      tag;
    logic [2:0] ph;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Lamp tables written from the phase/lamp definitions.
  function automatic logic [2:0] exp_la(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_lb(input logic [2:0] ph);
    case (ph)
      3'd4:    return 3'b001;
      3'd5:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // One clock: push the phase expected in this cycle, then apply inputs for
  // the next edge.
  task automatic drv(input string tag, input logic r, input logic a,
                     input logic b, input logic p, input logic [2:0] ph);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag = tag;
    e.ph  = ph;
    sb.push_back(e);
    reset   = r;
    Ta      = a;
    Tb      = b;
    ped_req = p;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        m_e = sb.pop_front();
        chk({m_e.tag, ".phase"}, 8'(phase), 8'(m_e.ph));
        chk({m_e.tag, ".LA"},    8'(LA),    8'(exp_la(m_e.ph)));
        chk({m_e.tag, ".LB"},    8'(LB),    8'(exp_lb(m_e.ph)));
        chk({m_e.tag, ".walk"},  8'(walk),
            8'((m_e.ph == 3'd3) || (m_e.ph == 3'd7)));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int len;

  initial begin
    reset = 1'b1; Ta = 1'b0; Tb = 1'b0; ped_req = 1'b0;
    reset4 = 1'b1; Ta4 = 1'b0; Tb4 = 1'b0; ped_req4 = 1'b0;

    // Held reset.
    repeat (100) drv("rst", 1, 0, 0, 0, 3'd0);

    // Release with demand on B only: min green then yellow, all-red, green B.
    drv("rel", 0, 0, 1, 0, 3'd0);
    drv("rel", 0, 0, 1, 0, 3'd0);
    drv("rel", 0, 0, 1, 0, 3'd1);
    drv("rel", 0, 0, 1, 0, 3'd1);
    drv("rel", 0, 0, 1, 0, 3'd2);
    drv("rel", 1, 0, 0, 0, 3'd4);

    // Both roads busy: max green on each side.
    repeat (4) drv("max", 0, 1, 1, 0, 3'd0);
    repeat (2) drv("max", 0, 1, 1, 0, 3'd1);
    drv("max", 0, 1, 1, 0, 3'd2);
    repeat (4) drv("max", 0, 1, 1, 0, 3'd4);
    repeat (2) drv("max", 0, 1, 1, 0, 3'd5);
    drv("max", 0, 1, 1, 0, 3'd6);
    drv("max", 0, 0, 1, 0, 3'd0);

    // Pedestrian pulse during green B with no traffic.
    drv("ped", 0, 0, 1, 0, 3'd0);
    repeat (2) drv("ped", 0, 0, 1, 0, 3'd1);
    drv("ped", 0, 0, 1, 0, 3'd2);
    drv("ped", 0, 0, 0, 1, 3'd4);
    drv("ped", 0, 0, 0, 0, 3'd4);
    repeat (2) drv("ped", 0, 0, 0, 0, 3'd5);
    drv("ped", 0, 0, 0, 0, 3'd6);
    repeat (3) drv("ped", 0, 0, 0, 0, 3'd7);
    // No demand: green A holds; request already served, so no walk next.
    repeat (6) drv("hold", 0, 0, 0, 0, 3'd0);
    drv("hold", 0, 0, 1, 0, 3'd0);
    repeat (2) drv("hold", 0, 0, 1, 0, 3'd1);
    drv("hold", 0, 0, 1, 0, 3'd2);
    drv("hold", 0, 1, 0, 0, 3'd4);

    // Press in the WALK_A entry cycle is served again at the next crossing.
    drv("reped", 0, 1, 0, 0, 3'd4);
    repeat (2) drv("reped", 0, 0, 0, 0, 3'd5);
    drv("reped", 0, 0, 0, 0, 3'd6);
    drv("reped", 0, 0, 0, 1, 3'd0);
    drv("reped", 0, 0, 0, 0, 3'd0);
    repeat (2) drv("reped", 0, 0, 0, 0, 3'd1);
    drv("reped", 0, 0, 0, 1, 3'd2);
    repeat (3) drv("reped", 0, 0, 0, 0, 3'd3);
    repeat (2) drv("reped", 0, 0, 0, 0, 3'd4);
    repeat (2) drv("reped", 0, 0, 0, 0, 3'd5);
    drv("reped", 0, 0, 0, 0, 3'd6);
    repeat (3) drv("reped", 0, 0, 0, 0, 3'd7);
    drv("reped", 0, 0, 1, 0, 3'd0);

    // Reset mid-YEL_B (with a press that reset must override).
    drv("midrst", 0, 0, 1, 0, 3'd0);
    repeat (2) drv("midrst", 0, 0, 1, 0, 3'd1);
    drv("midrst", 0, 1, 0, 0, 3'd2);
    drv("midrst", 0, 1, 0, 0, 3'd4);
    drv("midrst", 0, 1, 0, 0, 3'd4);
    drv("midrst", 1, 0, 0, 1, 3'd5);
    drv("midrst", 0, 0, 1, 0, 3'd0);
    drv("midrst", 0, 0, 1, 0, 3'd0);
    repeat (2) drv("midrst", 0, 0, 1, 0, 3'd1);
    drv("midrst", 0, 0, 0, 0, 3'd2);
    drv("midrst", 0, 0, 0, 0, 3'd4);
    drv("midrst", 0, 0, 0, 0, 3'd4);

    @(negedge clk);
    #1;
    chk("sb_drain", 8'(sb.size()), 8'd0);

    // Prescaled instance: each tick is 4 clocks.
    @(posedge clk);
    #1;
    reset4 = 1'b0; Tb4 = 1'b1;
    @(negedge clk);
    len = 0;
    while (phase4 === 3'd0 && len < 100) begin len++; @(negedge clk); end
    chk("td4.grn_len", 8'(len), 8'd8);
    len = 0;
    while (phase4 === 3'd1 && len < 100) begin len++; @(negedge clk); end
    chk("td4.yel_len", 8'(len), 8'd8);
    len = 0;
    while (phase4 === 3'd2 && len < 100) begin len++; @(negedge clk); end
    chk("td4.red_len", 8'(len), 8'd4);
    chk("td4.after_red", 8'(phase4), 8'd4);
    chk("td4.LB", 8'(LB4), 8'b001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sched.md
# traffic_phase_sched

Two-road intersection phase scheduler. Sequences road A and road B lights through green, yellow and all-red clearance, with programmable phase durations. It decides when to leave a green phase from the vehicle sensors, a minimum green time and a maximum green time, and inserts a latched pedestrian walk phase. It replaces the fixed-timer light FSM as the top-level lamp driver in the board design.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clk cycles per scheduler tick; 1 for simulation. Legal range ≥1.
- GREEN_MIN, 5: minimum green ticks before demand can end a green.
- GREEN_MAX, 20: green ticks after which pending demand forces a change. Must satisfy GREEN_MIN ≤ GREEN_MAX ≤ 255.
- YELLOW_T, 3: yellow ticks. Range 1..255.
- ALLRED_T, 1: all-red clearance ticks. Range 1..255.
- PED_T, 8: walk ticks. Range 1..255.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- Ta  in  1  vehicle present on road A.
- Tb  in  1  vehicle present on road B.
- ped_req  in  1  pedestrian button, level or pulse, sampled every clk.
- LA  out  3  road A lamps, one-hot: bit2 red, bit1 yellow, bit0 green.
- LB  out  3  road B lamps, same encoding.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state code, for debug.

## Operation
- The state register is 3 bits. Encoding:
  - GRN_A=0, YEL_A=1, RED_A=2, WALK_A=3
  - GRN_B=4, YEL_B=5, RED_B=6, WALK_B=7
- Outputs are Moore-decoded from the state register:
  - GRN_A: LA=001, LB=100.
  - YEL_A: LA=010, LB=100.
  - GRN_B: LA=100, LB=001.
  - YEL_B: LA=100, LB=010.
  - RED_x and WALK_x: LA=LB=100.
  - walk=1 only in WALK_A and WALK_B.
  - phase equals the state code.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where the count equals TICK_DIV-1. It is free-running and is not cleared on a state change.
- ph_cnt (8 bits): ticks completed in the current state.
  - On a tick with no transition, ph_cnt increments, saturating at 255.
  - On a transition, ph_cnt is cleared to 0.
  - Transition tests use n = ph_cnt+1 (saturating) evaluated in the tick cycle.
- Transitions are evaluated only in tick cycles.
- GRN_A: dem = Tb | ped_pend. Go to YEL_A if (n ≥ GREEN_MIN & dem & !Ta) | (n ≥ GREEN_MAX & dem). Otherwise stay. With no demand, GRN_A holds indefinitely.
- YEL_A goes to RED_A when n == YELLOW_T.
- RED_A: when n == ALLRED_T, go to WALK_A if ped_pend, else GRN_B.
- WALK_A goes to GRN_B when n == PED_T.
- The B side mirrors the A side: GRN_B (dem = Ta | ped_pend, hold term !Tb) → YEL_B → RED_B → WALK_B/GRN_A.
- ped_pend register:
  - Set on any cycle with ped_req=1.
  - Cleared in the cycle of the transition into WALK_A or WALK_B.
  - Set wins over clear. A press in the entry cycle leaves ped_pend=1, and the walk is served again at the next crossing.
- Reset, on the clk edge with reset=1, from any state and mid-phase:
  - state=GRN_A, prescaler=0, ph_cnt=0, ped_pend=0.
  - Outputs are therefore LA=001, LB=100, walk=0, phase=0.
  - reset overrides tick and ped_req in the same cycle.

## Timing
- Every transition occurs on a tick edge, so each state is entered aligned to a tick.
- A state of N ticks lasts exactly N*TICK_DIV clk cycles. The first state after reset is also aligned, because the prescaler restarts at 0.
- Inputs are sampled at the tick-cycle edge. Ta, Tb and ped_req values between ticks do not affect transitions, except that ped_req is latched into ped_pend on any cycle.
- Outputs change in the cycle after the transition edge, through the state-register decode. There is no combinational path from inputs to outputs.
- The phase sequence is never skipped. Every green-to-green change passes through yellow (YELLOW_T ticks) and all-red (ALLRED_T ticks).

## Test plan
Common parameters: TICK_DIV=1, GREEN_MIN=2, GREEN_MAX=4, YELLOW_T=2, ALLRED_T=1, PED_T=3.
- Reset with Ta=Tb=ped_req=0 for 100 cycles → LA=001, LB=100, walk=0, phase=0 throughout.
- Release reset with Ta=0, Tb=1 → phase sequence 0,0,1,1,2,4. LB=001 from the 6th cycle after release.
- Ta=Tb=1 held → GRN_A lasts exactly 4 cycles (max-green), YEL_A 2, RED_A 1. Then GRN_B lasts 4.
- ped_req pulse for 1 cycle during GRN_B with Ta=Tb=0:
  - Sequence 4(×2),5,5,6,7,7,7,0.
  - walk=1 for exactly 3 cycles.
  - ped_pend clears at WALK_B entry.
- ped_req=1 in the WALK_A entry cycle → ped_pend stays 1, and the next RED_B goes to WALK_B.
- Run TICK_DIV=4, YELLOW_T=2 → YEL_A lasts exactly 8 clk cycles.
- Assert reset mid-YEL_B → next edge gives phase=0, LA=001, and a full GREEN_MIN is applied again.
